// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: host-to-device PS/2 transmitter for command sequences of 1..MAX_BYTES bytes.
// Define PS2_CMD_ACK_CHECK_EN to enable device ACK checking, per-byte NACK retry and error_nack.
module ps2_command_sequencer #(
   parameter int unsigned INHIBIT_CYCLES       = 5050,
   parameter int unsigned START_TIMEOUT_CYCLES = 750000,
   parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
   parameter int unsigned MAX_BYTES            = 4,
   parameter int unsigned MAX_RETRIES          = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [8*MAX_BYTES-1:0]             the_command,
   input  logic [$clog2(MAX_BYTES+1)-1:0]     command_length,
   input  logic                               send_command,
   input  logic                               ps2_clk_posedge,
   input  logic                               ps2_clk_negedge,
   inout  wire                                PS2_CLK,
   inout  wire                                PS2_DAT,
   output logic                               command_was_sent,
   output logic                               error_communication_timed_out,
   output logic                               error_nack,
   output logic [$clog2(MAX_BYTES+1)-1:0]     bytes_sent
);

   localparam int unsigned LW      = $clog2(MAX_BYTES + 1);
   localparam int unsigned T_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
   localparam int unsigned T_MAX   = (T_MAX_A > XFER_TIMEOUT_CYCLES) ? T_MAX_A : XFER_TIMEOUT_CYCLES;
   localparam int unsigned CW      = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, WAIT_CLK, DATA, STOP, ACK, DONE, ERROR
   } state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_nx, lim;
   logic [3:0]             cur_bit;
   logic [8*MAX_BYTES-1:0] cmd_buf;
   logic [LW-1:0]          len_r, len_in;
   logic [7:0]             cur_byte;
   logic [8:0]             frame;
   logic                   ack_seen, ack_val, byte_ok, timeout;
   logic                   clk_low, dat_oe, dat_o;

   // bytes_sent doubles as the index of the byte currently on the wire
   assign len_in   = (command_length > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : command_length;
   assign cur_byte = 8'(cmd_buf >> {bytes_sent, 3'b000});
   assign frame    = {~^cur_byte, cur_byte};

   always_comb begin
      case (state)
         INHIBIT:         lim = CW'(INHIBIT_CYCLES);
         WAIT_CLK:        lim = CW'(START_TIMEOUT_CYCLES);
         DATA, STOP, ACK: lim = CW'(XFER_TIMEOUT_CYCLES);
         default:         lim = '0;
      endcase
   end

   assign cnt_nx  = (cnt < lim) ? cnt + 1'b1 : cnt;
   assign timeout = (cnt_nx == lim);

`ifdef PS2_CMD_ACK_CHECK_EN
   localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   logic [RW-1:0] retries;
   logic          ack_r, byte_retry, nack_fail, err_is_nack, error_nack_r;
   assign ack_val    = ack_r;
   assign error_nack = error_nack_r;
`else
   assign ack_val    = 1'b1;
   assign error_nack = 1'b0;
   if (MAX_RETRIES != 0) begin : g_retries_unused
   end
`endif

   always_comb begin
      state_n = state;
      byte_ok = 1'b0;
`ifdef PS2_CMD_ACK_CHECK_EN
      byte_retry = 1'b0;
      nack_fail  = 1'b0;
`endif
      case (state)
         IDLE:
            if (send_command) state_n = (len_in == '0) ? DONE : INHIBIT;
         INHIBIT:
            if (timeout) state_n = WAIT_CLK;
         WAIT_CLK:
            if (ps2_clk_negedge)                      state_n = DATA;
            else if (!ps2_clk_posedge && timeout)     state_n = ERROR;
         DATA:
            if (ps2_clk_negedge) begin
               if (cur_bit == 4'd8) state_n = STOP;
            end else if (!ps2_clk_posedge && timeout) state_n = ERROR;
         STOP:
            if (ps2_clk_negedge)                      state_n = ACK;
            else if (!ps2_clk_posedge && timeout)     state_n = ERROR;
         ACK:
            // only the posedge after the sampling negedge closes the byte
            if (!ps2_clk_negedge) begin
               if (ps2_clk_posedge && ack_seen) begin
                  if (ack_val) begin
                     byte_ok = 1'b1;
                     state_n = (bytes_sent + 1'b1 < len_r) ? INHIBIT : DONE;
                  end
`ifdef PS2_CMD_ACK_CHECK_EN
                  else if (retries < RW'(MAX_RETRIES)) begin
                     byte_retry = 1'b1;
                     state_n    = INHIBIT;
                  end else begin
                     nack_fail = 1'b1;
                     state_n   = ERROR;
                  end
`endif
               end else if (!ps2_clk_posedge && timeout) state_n = ERROR;
            end
         DONE, ERROR:
            if (!send_command) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                         <= IDLE;
         cnt                           <= '0;
         cur_bit                       <= '0;
         cmd_buf                       <= '0;
         len_r                         <= '0;
         bytes_sent                    <= '0;
         ack_seen                      <= 1'b0;
         command_was_sent              <= 1'b0;
         error_communication_timed_out <= 1'b0;
`ifdef PS2_CMD_ACK_CHECK_EN
         retries                       <= '0;
         ack_r                         <= 1'b0;
         err_is_nack                   <= 1'b0;
         error_nack_r                  <= 1'b0;
`endif
      end else begin
         state <= state_n;
         // STOP and ACK keep counting on the per-byte transfer budget started in DATA
         if ((state_n != state) && (state_n != STOP) && (state_n != ACK)) cnt <= '0;
         else                                                             cnt <= cnt_nx;

         if (state == WAIT_CLK)                                      cur_bit <= '0;
         else if (state == DATA && ps2_clk_negedge && cur_bit != 4'd8) cur_bit <= cur_bit + 1'b1;

         if (state != ACK)          ack_seen <= 1'b0;
         else if (ps2_clk_negedge)  ack_seen <= 1'b1;

         if (state == IDLE) begin
            cmd_buf    <= the_command;
            len_r      <= len_in;
            bytes_sent <= '0;
         end else if (byte_ok) begin
            bytes_sent <= bytes_sent + 1'b1;
         end

`ifdef PS2_CMD_ACK_CHECK_EN
         if (state == ACK && ps2_clk_negedge) ack_r <= (PS2_DAT == 1'b0);
         if (state == IDLE || byte_ok)        retries <= '0;
         else if (byte_retry)                 retries <= retries + 1'b1;
         if (state != ERROR)                  err_is_nack <= nack_fail;
         error_nack_r <= (state == ERROR) && send_command && err_is_nack;
         error_communication_timed_out <= (state == ERROR) && send_command && !err_is_nack;
`else
         error_communication_timed_out <= (state == ERROR) && send_command;
`endif
         command_was_sent <= (state == DONE) && send_command;
      end
   end

   always_comb begin
      clk_low = 1'b0;
      dat_oe  = 1'b0;
      dat_o   = 1'b0;
      case (state)
         INHIBIT: begin
            clk_low = 1'b1;
            dat_oe  = (cnt >= CW'(INHIBIT_CYCLES / 2));
         end
         WAIT_CLK: dat_oe = 1'b1;
         DATA: begin
            dat_oe = 1'b1;
            dat_o  = frame[cur_bit];
         end
         default: ;
      endcase
   end

   assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_oe ? dat_o : 1'bz;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed self-checking bench for ps2_command_sequencer with a clocked PS/2 device model.
module tb_ps2_command_sequencer;

   localparam int unsigned INH = 20;
   localparam int unsigned STO = 60;
   localparam int unsigned XTO = 300;
   localparam int unsigned MB  = 4;
   localparam int unsigned MR  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] the_command;
   logic [2:0]  command_length;
   logic        send_command;
   logic        pos, neg, dev_low;
   wire         ps2_clk, ps2_dat;
   logic        command_was_sent, error_communication_timed_out, error_nack;
   logic [2:0]  bytes_sent;

   int checks   = 0;
   int failures = 0;

   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_dat = dev_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   ps2_command_sequencer #(
      .INHIBIT_CYCLES      (INH),
      .START_TIMEOUT_CYCLES(STO),
      .XFER_TIMEOUT_CYCLES (XTO),
      .MAX_BYTES           (MB),
      .MAX_RETRIES         (MR)
   ) dut (
      .clk                          (clk),
      .reset                        (reset),
      .the_command                  (the_command),
      .command_length               (command_length),
      .send_command                 (send_command),
      .ps2_clk_posedge              (pos),
      .ps2_clk_negedge              (neg),
      .PS2_CLK                      (ps2_clk),
      .PS2_DAT                      (ps2_dat),
      .command_was_sent             (command_was_sent),
      .error_communication_timed_out(error_communication_timed_out),
      .error_nack                   (error_nack),
      .bytes_sent                   (bytes_sent)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit is_neg);
      repeat (3) tick();
      if (is_neg) neg = 1'b1;
      else        pos = 1'b1;
      tick();
      neg = 1'b0;
      pos = 1'b0;
   endtask

   task automatic wait_inhibit(output int low);
      int t;
      t   = 0;
      low = 0;
      while (ps2_clk !== 1'b0 && t < 200) begin tick(); t++; end
      while (ps2_clk === 1'b0 && low < 200) begin tick(); low++; end
   endtask

   task automatic dev_byte(input bit nack, output logic [8:0] fr, output logic sb,
                           output logic eb, output int low);
      wait_inhibit(low);
      sb = ps2_dat;
      pulse(1);
      for (int k = 0; k < 9; k++) begin
         fr[k] = ps2_dat;
         pulse(1);
      end
      eb = ps2_dat;
      pulse(1);
      pulse(0);
      dev_low = !nack;
      pulse(1);
      pulse(0);
      dev_low = 1'b0;
   endtask

   task automatic start_req(input logic [31:0] cmd, input logic [2:0] len);
      the_command    = cmd;
      command_length = len;
      send_command   = 1'b1;
   endtask

   task automatic end_req();
      send_command = 1'b0;
      tick();
      tick();
   endtask

   logic [8:0] fr;
   logic       sb, eb, quiet;
   int         low, n;
   logic [8:0] exp3 [3];
   logic [8:0] exp4 [4];

   initial begin
      reset = 1'b1; send_command = 1'b0; pos = 1'b0; neg = 1'b0; dev_low = 1'b0;
      the_command = '0; command_length = '0;
      exp3 = '{9'h1ED, 9'h007, 9'h0F4};
      exp4 = '{9'h001, 9'h002, 9'h103, 9'h004};
      #12;
      check("rst_clk_released", ps2_clk, 1'b1);
      check("rst_dat_released", ps2_dat, 1'b1);
      check("rst_sent", command_was_sent, 1'b0);
      check("rst_timeout", error_communication_timed_out, 1'b0);
      check("rst_nack", error_nack, 1'b0);
      check("rst_bytes", bytes_sent, 3'd0);
      tick(); reset = 1'b0; tick();

      // single byte F4
      start_req(32'h0000_00F4, 3'd1);
      dev_byte(1'b0, fr, sb, eb, low);
      check("f4_inhibit_len", low >= INH, 1'b1);
      check("f4_start_bit", sb, 1'b0);
      check("f4_frame", fr, 9'h0F4);
      check("f4_stop_bit", eb, 1'b1);
      tick();
      check("f4_done", command_was_sent, 1'b1);
      check("f4_bytes", bytes_sent, 3'd1);
      check("f4_no_timeout", error_communication_timed_out, 1'b0);
      send_command = 1'b0;
      tick();
      check("f4_flag_clear", command_was_sent, 1'b0);
      tick();

      // multi-byte ED 07 F4
      start_req(32'h00F4_07ED, 3'd3);
      for (int i = 0; i < 3; i++) begin
         dev_byte(1'b0, fr, sb, eb, low);
         check("multi_inhibit_len", low >= INH, 1'b1);
         check("multi_frame", fr, exp3[i]);
      end
      tick();
      check("multi_done", command_was_sent, 1'b1);
      check("multi_bytes", bytes_sent, 3'd3);
      end_req();

`ifdef PS2_CMD_ACK_CHECK_EN
      start_req(32'h0000_00F4, 3'd1);
      for (int i = 0; i < 3; i++) begin
         dev_byte(i < 2, fr, sb, eb, low);
         check("retry_frame", fr, 9'h0F4);
      end
      tick();
      check("retry_done", command_was_sent, 1'b1);
      check("retry_bytes", bytes_sent, 3'd1);
      end_req();
      start_req(32'h0000_00F4, 3'd1);
      for (int i = 0; i < 3; i++) dev_byte(1'b1, fr, sb, eb, low);
      tick();
      check("nack_error", error_nack, 1'b1);
      check("nack_bytes", bytes_sent, 3'd0);
      check("nack_not_timeout", error_communication_timed_out, 1'b0);
      check("nack_not_sent", command_was_sent, 1'b0);
      end_req();
`else
      start_req(32'h0000_00F4, 3'd1);
      dev_byte(1'b1, fr, sb, eb, low);
      tick();
      check("noack_done", command_was_sent, 1'b1);
      check("noack_no_nack", error_nack, 1'b0);
      check("noack_bytes", bytes_sent, 3'd1);
      end_req();
`endif

      // start timeout: no device clock at all
      start_req(32'h0000_00F4, 3'd1);
      repeat (INH + STO + 1) tick();
      check("start_to_early", error_communication_timed_out, 1'b0);
      tick();
      check("start_to_exact", error_communication_timed_out, 1'b1);
      check("start_to_not_nack", error_nack, 1'b0);
      send_command = 1'b0;
      tick();
      check("start_to_clear", error_communication_timed_out, 1'b0);
      tick();

      // transfer timeout: device stops after the first falling edge
      start_req(32'h0000_00F4, 3'd1);
      wait_inhibit(low);
      pulse(1);
      n = 0;
      while (error_communication_timed_out !== 1'b1 && n < XTO + 20) begin tick(); n++; end
      check("xfer_to_cycles", n, XTO + 1);
      end_req();

      // reset during INHIBIT releases the clock line at once
      start_req(32'h0000_00F4, 3'd1);
      tick(); tick();
      check("inh_clk_low", ps2_clk, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("inh_rst_clk", ps2_clk, 1'b1);
      send_command = 1'b0;
      tick(); reset = 1'b0; tick();

      // reset during DATA bit 4 of byte 00
      start_req(32'h0000_0000, 3'd1);
      wait_inhibit(low);
      pulse(1);
      repeat (4) pulse(1);
      check("mid_bit4_driven", ps2_dat, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_dat", ps2_dat, 1'b1);
      check("mid_rst_clk", ps2_clk, 1'b1);
      check("mid_rst_sent", command_was_sent, 1'b0);
      check("mid_rst_timeout", error_communication_timed_out, 1'b0);
      check("mid_rst_bytes", bytes_sent, 3'd0);
      send_command = 1'b0;
      tick(); reset = 1'b0; tick();
      start_req(32'h0000_00F4, 3'd1);
      dev_byte(1'b0, fr, sb, eb, low);
      check("post_rst_frame", fr, 9'h0F4);
      tick();
      check("post_rst_done", command_was_sent, 1'b1);
      end_req();

      // length 0: immediate DONE, bus untouched
      start_req(32'h0000_00F4, 3'd0);
      tick();
      quiet = (ps2_clk === 1'b1) && (ps2_dat === 1'b1);
      tick();
      quiet = quiet && (ps2_clk === 1'b1) && (ps2_dat === 1'b1);
      check("len0_done", command_was_sent, 1'b1);
      check("len0_quiet_bus", quiet, 1'b1);
      check("len0_bytes", bytes_sent, 3'd0);
      end_req();

      // length 7 clamps to MAX_BYTES=4
      start_req(32'h0403_0201, 3'd7);
      for (int i = 0; i < 4; i++) begin
         dev_byte(1'b0, fr, sb, eb, low);
         check("len7_frame", fr, exp4[i]);
      end
      tick();
      check("len7_done", command_was_sent, 1'b1);
      check("len7_bytes", bytes_sent, 3'd4);
      end_req();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
